// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and sizing for the Hi/Lo multiply/divide unit
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = MD_WIDTH;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add multiply or restoring-divide iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] a_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: {acc, a} is the 2*WIDTH product register, a[0] is the current multiplier bit
    sum     = {1'b0, acc_i} + ({1'b0, b_i} & {(WIDTH + 1){a_i[0]}});
    // Divide: acc is the partial remainder, a shifts dividend bits out and quotient bits in
    shifted = {acc_i, a_i[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - b_i;
    acc_o   = '0;
    a_o     = '0;
    if (is_div) begin
      if (shifted >= {1'b0, b_i}) begin
        acc_o = diff;
        a_o   = {a_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        a_o   = {a_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[WIDTH:1];
      a_o   = {sum[0], a_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - iterative multiply/divide engine owning the Hi/Lo registers
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(ITERS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   acc_step, a_step;
  logic               in_signed;
  logic [WIDTH-1:0]   abs_in1, abs_in2;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (div_q),
    .acc_i  (acc_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .acc_o  (acc_step),
    .a_o    (a_step)
  );

  always_comb begin
    in_signed = op_is_signed(op);
    abs_in1   = (in_signed && in1[WIDTH-1]) ? -in1 : in1;
    abs_in2   = (in_signed && in2[WIDTH-1]) ? -in2 : in2;
    prod_mag  = {acc_q, a_q};
    prod_fix  = neg_res_q ? -prod_mag : prod_mag;
    // A zero divisor leaves quotient all ones and remainder |in1|; re-signing the remainder restores in1
    quo_fix   = (b_q == '0) ? '1 : (neg_res_q ? -a_q : a_q);
    rem_fix   = neg_rem_q ? -acc_q : acc_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          div_d     = op_is_div(op);
          neg_res_d = in_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          neg_rem_d = in_signed & in1[WIDTH-1];
          acc_d     = '0;
          a_d       = abs_in1;
          b_d       = abs_in2;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        acc_d = acc_step;
        a_d   = a_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - vector table, random ops against an arithmetic model, MT/reset corner sequences
module tb_muldiv_hilo_unit;

  localparam logic [1:0] T_MULT  = 2'b00;
  localparam logic [1:0] T_MULTU = 2'b01;
  localparam logic [1:0] T_DIV   = 2'b10;
  localparam logic [1:0] T_DIVU  = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1, in2;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs [9];

  muldiv_hilo_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .in1     (in1),
    .in2     (in2),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint p;
    sa = a;
    sb = b;
    case (o)
      T_MULT: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      T_MULTU: return {32'h0, a} * {32'h0, b};
      T_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit mt_same);
    logic [63:0] exp;
    logic [31:0] hi32, lo32;
    int busy_n, done_n, done_k;
    exp = ref_op(o, a, b);
    hi32 = '0;
    lo32 = '0;
    @(negedge clock);
    op = o; in1 = a; in2 = b; start = 1'b1;
    if (mt_same) begin
      mtlo  = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    @(posedge clock); #1;
    start = 1'b0;
    mtlo  = 1'b0;
    busy_n = 0; done_n = 0; done_k = -1;
    for (int k = 0; k <= 34; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_k = k;
      end
      if (k == 32) begin
        hi32 = hi;
        lo32 = lo;
      end
      if (k == 33) chk({name, " result"}, {hi, lo}, exp);
      if (disturb && k == 5) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        wdata = $urandom; in1 = $urandom; in2 = $urandom; op = 2'($urandom);
      end
      if (disturb && k == 8) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      if (k < 34) begin
        @(posedge clock); #1;
      end
    end
    chk({name, " busy cycles"}, 64'(busy_n), 64'd33);
    chk({name, " done pulse"}, {32'(done_n), 32'(done_k)}, {32'd1, 32'd33});
    chk({name, " hold"}, {hi32, lo32}, {m_hi, m_lo});
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic mt_write(input string name, input bit wh, input bit wl, input logic [31:0] d);
    @(negedge clock);
    mthi = wh; mtlo = wl; wdata = d;
    @(posedge clock); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    chk({name, " hilo"}, {hi, lo}, {m_hi, m_lo});
    chk({name, " no done"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    vecs[0] = '{T_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{T_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{T_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
    vecs[4] = '{T_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[5] = '{T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{T_DIV,   32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF};
    vecs[7] = '{T_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{T_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    reset_n = 1'b0; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset hilo", {hi, lo}, 64'd0);
    chk("reset busy/done", 64'({busy, done}), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("vec%0d model", i), ref_op(vecs[i].op, vecs[i].a, vecs[i].b), {vecs[i].ehi, vecs[i].elo});
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
      chk($sformatf("vec%0d table", i), {hi, lo}, {vecs[i].ehi, vecs[i].elo});
    end

    mt_write("mthi", 1'b1, 1'b0, 32'hA5A5_A5A5);
    mt_write("mtlo", 1'b0, 1'b1, 32'h5A5A_0F0F);
    mt_write("mthi+mtlo", 1'b1, 1'b1, 32'h1357_9BDF);

    run_op("busy disturb", T_MULT, 32'h0001_2345, 32'hFFFF_0003, 1'b1, 1'b0);
    run_op("start+mtlo", T_DIVU, 32'h0000_0064, 32'h0000_0007, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, bit'($urandom_range(0, 1)), 1'b0);
    end

    @(negedge clock);
    op = T_MULT; in1 = 32'h1234_5678; in2 = 32'h0000_0009; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midop reset hilo", {hi, lo}, 64'd0);
    chk("midop reset busy/done", 64'({busy, done}), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clock);
    reset_n = 1'b1;
    run_op("post-reset div", T_DIV, 32'hFFFF_FF9C, 32'h0000_0007, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Multi-cycle multiply/divide engine that produces the Hi/Lo pair consumed by the datapath's MFHI/MFLO reads.
- Also accepts MTHI/MTLO writes, the write direction of the Hi/Lo interface.
- Replaces single-cycle negedge multiply/divide with a 32-iteration shift-add / restoring-divide FSM.
- Exposes a busy flag so the hazard logic can stall MFHI/MFLO and new mult/div issues.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are each WIDTH bits.
- ITERS, WIDTH, iterations per operation; this block must keep ITERS equal to WIDTH.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  issue an operation; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- in1  in  WIDTH  multiplicand / dividend.
- in2  in  WIDTH  multiplier / divisor.
- mthi  in  1  write wdata to hi.
- mtlo  in  1  write wdata to lo.
- wdata  in  WIDTH  MTHI/MTLO write data.
- hi  out  WIDTH  Hi register (product[63:32] / remainder).
- lo  out  WIDTH  Lo register (product[31:0] / quotient).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when hi/lo are updated by an operation.

Behaviour:
- Reset (async, reset_n=0):
  - hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
  - Reset asserted mid-operation aborts it; no partial result is written.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1: latch op and sign flags; load abs(in1) and abs(in2) (raw values for MULTU/DIVU); clear the accumulator/remainder; counter=0; go to RUN.
  - start has priority over mthi/mtlo in the same cycle. The MT write is dropped.
  - Without start, mthi/mtlo write wdata to hi/lo on the edge. Both asserted together write both registers.
- RUN:
  - One iteration per edge.
  - Multiply: unsigned shift-add, 64-bit product.
  - Divide: restoring, one quotient bit per edge.
  - After the 32nd iteration edge, go to FIX.
- FIX (one edge):
  - Apply sign correction, write hi/lo, assert done for exactly the following cycle, return to IDLE.
- Latency:
  - start sampled at edge E.
  - hi/lo hold the new values after edge E+33.
  - done=1 during cycle E+33..E+34.
  - busy=1 after edge E through edge E+33 (RUN and FIX states), 0 in IDLE.
  - A back-to-back start is accepted at edge E+34.
- While busy:
  - start is ignored (no queueing).
  - mthi/mtlo are ignored.
  - hi/lo hold their previous values until the FIX edge.
- Signed multiply: result negated when the operand signs differ; full 64-bit two's complement.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Invariant: in1 = lo*in2 + hi.
- Divide by zero (DIV and DIVU): lo=all ones, hi=in1 unchanged, same 33-cycle latency, done pulses normally.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are captured at start. Changes on in1/in2/op during RUN have no effect.
- done never asserts for MTHI/MTLO writes.

Decomposition:
- Shared package (muldiv_pkg):
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State enum IDLE/RUN/FIX.
  - Width and iteration constants.
- One natural sub-module: muldiv_step.
  - Combinational single iteration.
  - Inputs: mode, accumulator/remainder, operand shift registers.
  - Outputs: next-state values.
  - Instantiated once inside the FSM.

Test Plan:
- MULT in1=7, in2=0xFFFFFFFD -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high exactly 1 cycle; busy high for 33 cycles.
- MULTU in1=in2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV in1=0xFFFFFFF9 (-7), in2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=1.
- DIVU in1=0x1234, in2=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi wdata=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next edge. mtlo and start issued while busy -> ignored, final result unaffected. start+mtlo in the same IDLE cycle -> op runs, lo gets the op result only.
- Pulse reset_n low at cycle 10 of a MULT -> hi=lo=0, busy=0 immediately. A new DIV issued after release completes correctly in 33 cycles.
